// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-clock divider, x/y counters, registered
// sync/blank decode, line/frame strobes and a wrapping frame counter.
module vga_timing_gen #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned HSYNC_POL = 0,
   parameter int unsigned VSYNC_POL = 0,
   parameter int unsigned CNT_W     = 10
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   output logic             pixel_tick_o,
   output logic [CNT_W-1:0] pixel_x_o,
   output logic [CNT_W-1:0] pixel_y_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             video_on_o,
   output logic             line_end_o,
   output logic             frame_start_o,
   output logic [7:0]       frame_count_o
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic             HS_ACT   = (HSYNC_POL != 0);
   localparam logic             VS_ACT   = (VSYNC_POL != 0);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic [7:0]       frame_q, frame_d;
   logic             hsync_q, vsync_q, video_q;
   logic             line_end_q, frame_start_q;
   logic             tick, x_wrap, y_wrap;
   logic             hs_in, vs_in;

   assign tick   = enable_i && (div_q == DIV_LAST);
   assign x_wrap = (x_q == X_LAST);
   assign y_wrap = (y_q == Y_LAST);
   assign hs_in  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
   assign vs_in  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

   always_comb begin
      div_d   = div_q;
      x_d     = x_q;
      y_d     = y_q;
      frame_d = frame_q;
      if (enable_i) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
      if (tick) begin
         if (x_wrap) begin
            x_d = '0;
            if (y_wrap) begin
               y_d     = '0;
               frame_d = frame_q + 8'd1;
            end else begin
               y_d = y_q + 1'b1;
            end
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         frame_q       <= '0;
         hsync_q       <= ~HS_ACT;
         vsync_q       <= ~VS_ACT;
         video_q       <= 1'b0;
         line_end_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         x_q     <= x_d;
         y_q     <= y_d;
         frame_q <= frame_d;
         // Decode follows the pre-update x/y, giving the fixed one-clk lag.
         if (enable_i) begin
            hsync_q <= hs_in ? HS_ACT : ~HS_ACT;
            vsync_q <= vs_in ? VS_ACT : ~VS_ACT;
            video_q <= (x_q < X_VIS) && (y_q < Y_VIS);
         end
         line_end_q    <= tick && x_wrap;
         frame_start_q <= tick && x_wrap && y_wrap;
      end
   end

   // Strobes are masked combinationally so a freeze or reset silences them at once.
   assign pixel_tick_o  = tick && !reset_i;
   assign line_end_o    = line_end_q && enable_i;
   assign frame_start_o = frame_start_q && enable_i;
   assign pixel_x_o     = x_q;
   assign pixel_y_o     = y_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign video_on_o    = video_q;
   assign frame_count_o = frame_q;

endmodule
